m_tplatch_wr_seq: RTL and testbench

// - Write sequencer upstream of the TPLATCH1 transparent latch banks; drives their D and EB.
// - Accepts one write request (address, data) per valid/ready handshake.
// - Drives D stable, then opens one bank's EB for a fixed number of MasterClock cycles.
// - Keeps D stable for the setup and hold windows around the EB pulse, then pulses done.
// - Keeps latch timing correct in the single-clock MasterClock model: D never changes while any EB is high.

---
 rtl/m_tplatch_wr_seq.sv | 183 ++++++++++++++++++
 tb/tb_m_tplatch_wr_seq.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/m_tplatch_wr_seq.sv
`timescale 1ns/100ps
// -----------------------------------------------------------------------------
// m_tplatch_wr_seq
//
// Write sequencer for a set of TPLATCH1 transparent latch banks. It accepts one
// (address, data) write per valid/ready handshake. It then drives the shared
// data bus D and opens exactly one bank enable EB for PULSE clock cycles. D is
// held stable for SETUP cycles before the enable rises and for HOLD cycles after
// it falls. The sequencer then returns to idle with a one-cycle done pulse.
// D only changes on an accept edge, and an accept can only happen while every
// EB is low. In the single-clock model, D therefore never moves under an open
// latch.
//
// Parameters
//   WIDTH  data width of D / req_data
//   ADDRW  bank address width; 2**ADDRW enables on EB
//   SETUP  cycles D is stable before EB rises (0 allowed)
//   PULSE  cycles EB is high (>= 1)
//   HOLD   cycles D is stable after EB falls (0 allowed)
//
// Ports
//   MasterClock  in   system clock, rising-edge
//   reset        in   asynchronous reset, active-high
//   req_valid    in   write request present
//   req_ready    out  sequencer idle; accept on valid & ready
//   req_addr     in   target latch bank
//   req_data     in   data to be latched
//   D            out  data to all latch banks
//   EB           out  one-hot latch enables, bit n drives bank n
//   busy         out  transaction in progress (~req_ready)
//   done         out  one-cycle pulse when a transaction completes
// -----------------------------------------------------------------------------
module m_tplatch_wr_seq #(
  parameter int WIDTH = 8,
  parameter int ADDRW = 2,
  parameter int SETUP = 1,
  parameter int PULSE = 2,
  parameter int HOLD  = 1
) (
  input  logic                    MasterClock,
  input  logic                    reset,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [ADDRW-1:0]        req_addr,
  input  logic [WIDTH-1:0]        req_data,
  output logic [WIDTH-1:0]        D,
  output logic [(2**ADDRW)-1:0]   EB,
  output logic                    busy,
  output logic                    done
);

  localparam int NBANK  = 2**ADDRW;
  localparam int MAXSP  = (SETUP > PULSE) ? SETUP : PULSE;
  localparam int MAXLEN = (MAXSP > HOLD) ? MAXSP : HOLD;
  localparam int CNTW   = $clog2(MAXLEN + 1);

  // Counter reload values: each state's length minus one. A zero-length
  // window is never entered, so its reload value is irrelevant.
  localparam logic [CNTW-1:0] C_SETUP = CNTW'((SETUP > 0) ? SETUP - 1 : 0);
  localparam logic [CNTW-1:0] C_PULSE = CNTW'((PULSE > 0) ? PULSE - 1 : 0);
  localparam logic [CNTW-1:0] C_HOLD  = CNTW'((HOLD  > 0) ? HOLD  - 1 : 0);
  localparam logic [CNTW-1:0] C_ONE   = CNTW'(1);

  if (PULSE < 1) begin : g_bad_pulse
    $error("m_tplatch_wr_seq: PULSE must be >= 1");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETUP,
    S_OPEN,
    S_HOLD
  } state_t;

  state_t              r_state, w_state_nxt;
  logic [CNTW-1:0]     r_cnt, w_cnt_nxt;
  logic [WIDTH-1:0]    r_d;
  logic [ADDRW-1:0]    r_bank, w_bank_nxt;
  logic [NBANK-1:0]    r_eb, w_eb_nxt;
  logic                r_done, w_done_nxt;
  logic                w_accept;

  assign w_accept = req_valid && (r_state == S_IDLE);

  // NOTE: every always_comb output gets a default first, so that no path
  // through the case leaves a signal unassigned and infers a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_done_nxt  = 1'b0;
    w_bank_nxt  = w_accept ? req_addr : r_bank;

    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (SETUP > 0) begin
            w_state_nxt = S_SETUP;
            w_cnt_nxt   = C_SETUP;
          end else begin
            w_state_nxt = S_OPEN;
            w_cnt_nxt   = C_PULSE;
          end
        end
      end
      S_SETUP: begin
        if (r_cnt == '0) begin
          w_state_nxt = S_OPEN;
          w_cnt_nxt   = C_PULSE;
        end else begin
          w_cnt_nxt = r_cnt - C_ONE;
        end
      end
      S_OPEN: begin
        if (r_cnt == '0) begin
          if (HOLD > 0) begin
            w_state_nxt = S_HOLD;
            w_cnt_nxt   = C_HOLD;
          end else begin
            w_state_nxt = S_IDLE;
            w_done_nxt  = 1'b1;
          end
        end else begin
          w_cnt_nxt = r_cnt - C_ONE;
        end
      end
      S_HOLD: begin
        if (r_cnt == '0) begin
          w_state_nxt = S_IDLE;
          w_done_nxt  = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt - C_ONE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    // EB is registered from the next state, so it is high exactly while the
    // state register holds OPEN. Indexing a zeroed vector keeps it one-hot.
    w_eb_nxt = '0;
    if (w_state_nxt == S_OPEN) begin
      w_eb_nxt[w_bank_nxt] = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // flop samples pre-edge values regardless of statement order.
  always_ff @(posedge MasterClock or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // The async reset clears EB immediately, so an open latch closes without
  // waiting for a clock edge. The bank keeps whatever it already captured.
  always_ff @(posedge MasterClock or posedge reset) begin
    if (reset) begin
      r_d    <= '0;
      r_bank <= '0;
      r_eb   <= '0;
      r_done <= 1'b0;
    end else begin
      if (w_accept) begin
        r_d    <= req_data;
        r_bank <= req_addr;
      end
      r_eb   <= w_eb_nxt;
      r_done <= w_done_nxt;
    end
  end

  assign D         = r_d;
  assign EB        = r_eb;
  assign done      = r_done;
  assign req_ready = (r_state == S_IDLE);
  assign busy      = ~req_ready;

endmodule

// File: tb/tb_m_tplatch_wr_seq.sv
`timescale 1ns/100ps
// -----------------------------------------------------------------------------
// tb_m_tplatch_wr_seq
//
// This bench drives two sequencer instances from one clock.
//   dut   : default windows (SETUP=1 PULSE=2 HOLD=1)
//   dut_z : zero setup/hold windows (SETUP=0 PULSE=2 HOLD=0)
//
// The reference model tracks each transaction by its age, measured in cycles
// since the accept edge. All expected outputs are derived from that age using
// the window lengths. A behavioural latch bank per EB bit captures D while its
// enable is high. The bank is sampled at half-nanosecond offsets, so it never
// races a clock or reset edge.
// -----------------------------------------------------------------------------
module tb_m_tplatch_wr_seq;

  localparam int WIDTH    = 8;
  localparam int ADDRW    = 2;
  localparam int NBANK    = 4;
  localparam int S0 = 1, P0 = 2, H0 = 1;
  localparam int S1 = 0, P1 = 2, H1 = 0;
  localparam int IDLE_AGE = 1000;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             valid, valid_z;
  logic [ADDRW-1:0] addr, addr_z;
  logic [WIDTH-1:0] data, data_z;
  logic             ready, busy, done;
  logic             ready_z, busy_z, done_z;
  logic [WIDTH-1:0] d, d_z;
  logic [NBANK-1:0] eb, eb_z;

  int total = 0;
  int bad   = 0;

  logic [WIDTH-1:0] bank_q [NBANK];

  m_tplatch_wr_seq #(
    .WIDTH(WIDTH), .ADDRW(ADDRW), .SETUP(S0), .PULSE(P0), .HOLD(H0)
  ) dut (
    .MasterClock(clk), .reset(rst),
    .req_valid(valid), .req_ready(ready),
    .req_addr(addr), .req_data(data),
    .D(d), .EB(eb), .busy(busy), .done(done)
  );

  m_tplatch_wr_seq #(
    .WIDTH(WIDTH), .ADDRW(ADDRW), .SETUP(S1), .PULSE(P1), .HOLD(H1)
  ) dut_z (
    .MasterClock(clk), .reset(rst),
    .req_valid(valid_z), .req_ready(ready_z),
    .req_addr(addr_z), .req_data(data_z),
    .D(d_z), .EB(eb_z), .busy(busy_z), .done(done_z)
  );

  always #5 clk = ~clk;

  // Transparent latch banks on the main instance, sampled mid-step.
  initial begin
    for (int n = 0; n < NBANK; n++) bank_q[n] = '0;
    #0.5;
    forever begin
      for (int n = 0; n < NBANK; n++) begin
        if (eb[n]) bank_q[n] = d;
      end
      #1;
    end
  end

  // ---------------- reference model ----------------
  int               m_age  [2];
  logic [WIDTH-1:0] m_d    [2];
  logic [ADDRW-1:0] m_bank [2];

  function automatic int s_of(int i); return (i == 0) ? S0 : S1; endfunction
  function automatic int p_of(int i); return (i == 0) ? P0 : P1; endfunction
  function automatic int len(int i);
    return (i == 0) ? (S0 + P0 + H0) : (S1 + P1 + H1);
  endfunction
  function automatic logic exp_ready(int i); return m_age[i] > len(i); endfunction
  function automatic logic exp_done(int i); return m_age[i] == len(i) + 1; endfunction
  function automatic logic [NBANK-1:0] exp_eb(int i);
    logic [NBANK-1:0] v;
    v = '0;
    if (m_age[i] >= s_of(i) + 1 && m_age[i] <= s_of(i) + p_of(i)) v[m_bank[i]] = 1'b1;
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_age[i]  = IDLE_AGE;
      m_d[i]    = '0;
      m_bank[i] = '0;
    end
  endtask

  // Advance one clock: update the model with the pre-edge inputs, then move
  // to 1 ns after the edge, where outputs are settled and inputs may change.
  task automatic tick();
    logic acc0, acc1;
    @(posedge clk);
    acc0 = valid   && exp_ready(0) && !rst;
    acc1 = valid_z && exp_ready(1) && !rst;
    if (acc0) begin
      m_age[0] = 1; m_d[0] = data; m_bank[0] = addr;
    end else if (m_age[0] < IDLE_AGE) m_age[0]++;
    if (acc1) begin
      m_age[1] = 1; m_d[1] = data_z; m_bank[1] = addr_z;
    end else if (m_age[1] < IDLE_AGE) m_age[1]++;
    if (rst) model_reset();
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    #2;
    total++;
    if ({d, eb, ready, busy, done} !== {8'h00, 4'b0000, 3'b100}) begin
      bad++;
      $display("FAIL reset_main got d=%h eb=%b rdy=%b busy=%b done=%b want 00 0000 1 0 0",
               d, eb, ready, busy, done);
    end
    total++;
    if ({d_z, eb_z, ready_z, busy_z, done_z} !== {8'h00, 4'b0000, 3'b100}) begin
      bad++;
      $display("FAIL reset_zero got d=%h eb=%b rdy=%b busy=%b done=%b want 00 0000 1 0 0",
               d_z, eb_z, ready_z, busy_z, done_z);
    end
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_idle();
    for (int c = 0; c < 20; c++) begin
      tick();
      total++;
      if ({d, eb, done} !== {8'h00, 4'b0000, 1'b0}) begin
        bad++;
        $display("FAIL idle c=%0d got d=%h eb=%b done=%b want 00 0000 0", c, d, eb, done);
      end
    end
  endtask

  // Accept in cycle 0; checks cycles 1..5 and ends in cycle 5.
  task automatic test_single_write();
    logic [NBANK-1:0] w_eb;
    valid = 1'b1; addr = 2'd2; data = 8'hA5;
    tick();
    valid = 1'b0; addr = '0; data = '0;
    for (int c = 1; c <= 5; c++) begin
      w_eb = (c == 2 || c == 3) ? 4'b0100 : 4'b0000;
      total++;
      if ({d, eb, done, ready} !== {8'hA5, w_eb, (c == 5), (c == 5)}) begin
        bad++;
        $display("FAIL single c=%0d got d=%h eb=%b done=%b rdy=%b want A5 %b %0d %0d",
                 c, d, eb, done, ready, w_eb, (c == 5), (c == 5));
      end
      if (c < 5) tick();
    end
    total++;
    if (bank_q[2] !== 8'hA5) begin
      bad++;
      $display("FAIL single_bank2 got %h want a5", bank_q[2]);
    end
  endtask

  // Runs from cycle 5 of the previous write; accept at the cycle-5 edge.
  task automatic test_back_to_back();
    logic [NBANK-1:0] w_eb;
    valid = 1'b1; addr = 2'd1; data = 8'h3C;
    #2;
    total++;
    if (d !== 8'hA5) begin
      bad++;
      $display("FAIL b2b_pre_edge got d=%h want a5", d);
    end
    tick();
    valid = 1'b0;
    for (int c = 6; c <= 10; c++) begin
      w_eb = (c == 7 || c == 8) ? 4'b0010 : 4'b0000;
      total++;
      if ({d, eb, done} !== {8'h3C, w_eb, (c == 10)}) begin
        bad++;
        $display("FAIL b2b c=%0d got d=%h eb=%b done=%b want 3c %b %0d",
                 c, d, eb, done, w_eb, (c == 10));
      end
      if (c < 10) tick();
    end
  endtask

  task automatic test_busy_ignore();
    valid = 1'b1; addr = 2'd2; data = 8'hA5;
    tick();
    addr = 2'd0; data = 8'hFF;
    for (int c = 1; c <= 4; c++) begin
      total++;
      if (d !== 8'hA5 || eb[0] !== 1'b0 || busy !== 1'b1) begin
        bad++;
        $display("FAIL busy_ignore c=%0d got d=%h eb0=%b busy=%b want a5 0 1", c, d, eb[0], busy);
      end
      tick();
    end
    total++;
    if (done !== 1'b1 || ready !== 1'b1) begin
      bad++;
      $display("FAIL busy_c5 got done=%b rdy=%b want 1 1", done, ready);
    end
    tick();
    valid = 1'b0;
    total++;
    if (d !== 8'hFF || busy !== 1'b1) begin
      bad++;
      $display("FAIL busy_accept got d=%h busy=%b want ff 1", d, busy);
    end
    for (int c = 0; c < 5; c++) tick();
  endtask

  task automatic test_reset_mid_op();
    valid = 1'b1; addr = 2'd3; data = 8'hA5;
    tick();
    valid = 1'b0;
    tick();
    total++;
    if (eb !== 4'b1000) begin
      bad++;
      $display("FAIL midrst_open got eb=%b want 1000", eb);
    end
    #1.3;
    rst = 1'b1;
    #0.2;
    total++;
    if ({eb, d, ready, busy} !== {4'b0000, 8'h00, 2'b10}) begin
      bad++;
      $display("FAIL midrst_async got eb=%b d=%h rdy=%b busy=%b want 0000 00 1 0",
               eb, d, ready, busy);
    end
    tick();
    rst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      tick();
      total++;
      if (done !== 1'b0 || eb !== 4'b0000) begin
        bad++;
        $display("FAIL midrst_nodone c=%0d got done=%b eb=%b want 0 0000", c, done, eb);
      end
    end
    total++;
    if (bank_q[3] !== 8'hA5) begin
      bad++;
      $display("FAIL midrst_bank3 got %h want a5", bank_q[3]);
    end
  endtask

  task automatic test_zero_windows();
    logic [NBANK-1:0] w_eb;
    valid_z = 1'b1; addr_z = 2'd1; data_z = 8'h69;
    tick();
    valid_z = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      w_eb = (c <= 2) ? 4'b0010 : 4'b0000;
      total++;
      if ({d_z, eb_z, done_z} !== {8'h69, w_eb, (c == 3)}) begin
        bad++;
        $display("FAIL zero c=%0d got d=%h eb=%b done=%b want 69 %b %0d",
                 c, d_z, eb_z, done_z, w_eb, (c == 3));
      end
      if (c < 3) tick();
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      valid   = ($urandom_range(0, 2) != 0);
      addr    = ADDRW'($urandom);
      data    = WIDTH'($urandom);
      valid_z = ($urandom_range(0, 2) != 0);
      addr_z  = ADDRW'($urandom);
      data_z  = WIDTH'($urandom);
      tick();
      total++;
      if ({d, eb, ready, busy, done} !==
          {m_d[0], exp_eb(0), exp_ready(0), !exp_ready(0), exp_done(0)}) begin
        bad++;
        $display("FAIL rand_main c=%0d got d=%h eb=%b r=%b b=%b dn=%b want %h %b %b %b %b",
                 c, d, eb, ready, busy, done,
                 m_d[0], exp_eb(0), exp_ready(0), !exp_ready(0), exp_done(0));
      end
      total++;
      if ({d_z, eb_z, ready_z, busy_z, done_z} !==
          {m_d[1], exp_eb(1), exp_ready(1), !exp_ready(1), exp_done(1)}) begin
        bad++;
        $display("FAIL rand_zero c=%0d got d=%h eb=%b r=%b b=%b dn=%b want %h %b %b %b %b",
                 c, d_z, eb_z, ready_z, busy_z, done_z,
                 m_d[1], exp_eb(1), exp_ready(1), !exp_ready(1), exp_done(1));
      end
    end
    valid = 1'b0; valid_z = 1'b0;
  endtask

  initial begin
    valid = 1'b0; addr = '0; data = '0;
    valid_z = 1'b0; addr_z = '0; data_z = '0;
    model_reset();
    test_reset();
    test_idle();
    test_single_write();
    test_back_to_back();
    test_busy_ignore();
    test_reset_mid_op();
    test_zero_windows();
    for (int c = 0; c < 3; c++) tick();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
